// File: rtl/recv_packet.sv
// USB packet receiver: sorts SIE bytes into PID, payload and status,
// holding back the trailing CRC16 bytes with a two-byte delay line.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   getPacketEn/getPacketRdy request one packet / idle with results valid
//   RxByteIn, RxCntlIn       byte from the SIE and its type (START/DATA/STOP)
//   RxByteValid, RxTimeOut   byte strobe, response-window timeout strobe
//   RxFifoData, RxFifoWEn    payload byte and write strobe to the RX FIFO
//   RxFifoFull               FIFO cannot accept a write this cycle
//   RxPID, pidError          PID nibble of the last START byte, PID check failure
//   RxStatus, RxByteCount    packet status flags, payload bytes written
module recv_packet (
  input  logic       clk,
  input  logic       rst,
  input  logic       getPacketEn,
  output logic       getPacketRdy,
  input  logic [7:0] RxByteIn,
  input  logic [7:0] RxCntlIn,
  input  logic       RxByteValid,
  input  logic       RxTimeOut,
  output logic [7:0] RxFifoData,
  output logic       RxFifoWEn,
  input  logic       RxFifoFull,
  output logic [3:0] RxPID,
  output logic [7:0] RxStatus,
  output logic       pidError,
  output logic [9:0] RxByteCount
);

  typedef enum logic [2:0] {
    IDLE, WAIT_PID, DATA, HSHK, DONE
  } state_t;

  state_t state, nextState;

  logic       isStart, isData, isStop;
  logic [3:0] pid;
  logic       pidBad, pidIsData;
  logic [7:0] line0, line1;
  logic [1:0] fill;
  logic       pending;
  logic [7:0] pendData;

  assign isStart = RxByteValid && (RxCntlIn == 8'h01);
  assign isData  = RxByteValid && (RxCntlIn == 8'h02);
  assign isStop  = RxByteValid && (RxCntlIn == 8'h03);

  assign pid       = RxByteIn[3:0];
  assign pidBad    = RxByteIn[7:4] != ~RxByteIn[3:0];
  assign pidIsData = !pidBad && (pid == 4'h3 || pid == 4'hB);

  // The emitted byte is registered; the FIFO full flag is judged in the
  // cycle the write is actually presented.
  assign RxFifoData = pendData;
  assign RxFifoWEn  = pending && !RxFifoFull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState    = state;
    getPacketRdy = 1'b0;
    unique case (state)
      IDLE: begin
        getPacketRdy = 1'b1;
        if (getPacketEn) nextState = WAIT_PID;
      end
      WAIT_PID: begin
        if (isStart)        nextState = pidIsData ? DATA : HSHK;
        else if (RxTimeOut) nextState = DONE;
      end
      DATA, HSHK: begin
        if (isStart)     nextState = pidIsData ? DATA : HSHK;
        else if (isStop) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RxPID       <= 4'h0;
      RxStatus    <= 8'h00;
      pidError    <= 1'b0;
      RxByteCount <= 10'd0;
      line0       <= 8'h00;
      line1       <= 8'h00;
      fill        <= 2'd0;
      pending     <= 1'b0;
      pendData    <= 8'h00;
    end else begin
      pending <= 1'b0;
      if (pending) begin
        if (RxFifoFull)                  RxStatus[2] <= 1'b1;
        else if (RxByteCount != 10'd1023) RxByteCount <= RxByteCount + 10'd1;
      end
      unique case (state)
        IDLE: begin
          if (getPacketEn) begin
            RxPID       <= 4'h0;
            RxStatus    <= 8'h00;
            pidError    <= 1'b0;
            RxByteCount <= 10'd0;
            fill        <= 2'd0;
          end
        end
        WAIT_PID, DATA, HSHK: begin
          if (isStart) begin
            // A START outside WAIT_PID restarts the packet from scratch.
            RxPID         <= pid;
            pidError      <= pidBad;
            RxByteCount   <= 10'd0;
            fill          <= 2'd0;
            RxStatus[6:0] <= {pidIsData && pid == 4'hB,
                              !pidBad && pid == 4'h2,
                              !pidBad && pid == 4'hE,
                              !pidBad && pid == 4'hA,
                              3'b000};
          end else if (state == WAIT_PID) begin
            if (RxTimeOut) RxStatus[7] <= 1'b1;
          end else if (isStop) begin
            RxStatus[1:0] <= RxByteIn[1:0];
            fill          <= 2'd0;
          end else if (isData && state == DATA) begin
            if (fill == 2'd2) begin
              pending  <= 1'b1;
              pendData <= line1;
            end else begin
              fill <= fill + 2'd1;
            end
            line1 <= line0;
            line0 <= RxByteIn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_packet.sv
// Directed bench for recv_packet: scoreboard of expected FIFO bytes
// popped by a write monitor, plus status checks after each packet.
module tb_recv_packet;

  logic       clk = 1'b0;
  logic       rst;
  logic       getPacketEn;
  logic       getPacketRdy;
  logic [7:0] RxByteIn;
  logic [7:0] RxCntlIn;
  logic       RxByteValid;
  logic       RxTimeOut;
  logic [7:0] RxFifoData;
  logic       RxFifoWEn;
  logic       RxFifoFull;
  logic [3:0] RxPID;
  logic [7:0] RxStatus;
  logic       pidError;
  logic [9:0] RxByteCount;

  int nCompared = 0;
  int nMismatch = 0;
  logic [7:0] expQ[$];

  recv_packet dut (
    .clk(clk), .rst(rst),
    .getPacketEn(getPacketEn), .getPacketRdy(getPacketRdy),
    .RxByteIn(RxByteIn), .RxCntlIn(RxCntlIn),
    .RxByteValid(RxByteValid), .RxTimeOut(RxTimeOut),
    .RxFifoData(RxFifoData), .RxFifoWEn(RxFifoWEn),
    .RxFifoFull(RxFifoFull), .RxPID(RxPID),
    .RxStatus(RxStatus), .pidError(pidError),
    .RxByteCount(RxByteCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RxFifoWEn === 1'b1) begin
      if (expQ.size() == 0) begin
        chk("unexpected_write", {24'h0, RxFifoData}, 32'hFFFF_FFFF);
      end else begin
        chk("fifo_data", {24'h0, RxFifoData}, {24'h0, expQ.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] cntl, input logic [7:0] b);
    RxByteValid = 1'b1;
    RxCntlIn    = cntl;
    RxByteIn    = b;
    tick();
    RxByteValid = 1'b0;
    RxCntlIn    = 8'h00;
    RxByteIn    = 8'h00;
  endtask

  task automatic request();
    getPacketEn = 1'b1;
    tick();
    getPacketEn = 1'b0;
    chk("rdy_busy", {31'h0, getPacketRdy}, 32'h0);
  endtask

  // STOP, then check ready stays low in DONE and rises one cycle later.
  task automatic stopPacket(input logic [7:0] b);
    sendByte(8'h03, b);
    chk("rdy_done", {31'h0, getPacketRdy}, 32'h0);
    tick();
    chk("rdy_idle", {31'h0, getPacketRdy}, 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    getPacketEn = 1'b0;
    RxByteIn = 8'h00;
    RxCntlIn = 8'h00;
    RxByteValid = 1'b0;
    RxTimeOut = 1'b0;
    RxFifoFull = 1'b0;
    #1;
    chk("rst_rdy", {31'h0, getPacketRdy}, 32'h1);
    chk("rst_status", {24'h0, RxStatus}, 32'h0);
    chk("rst_wen", {31'h0, RxFifoWEn}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // ACK handshake
    request();
    sendByte(8'h01, 8'hD2);
    stopPacket(8'h00);
    chk("ack_pid", {28'h0, RxPID}, 32'h2);
    chk("ack_status", {24'h0, RxStatus}, 32'h20);
    chk("ack_count", {22'h0, RxByteCount}, 32'h0);

    // DATA1 with CRC stripped
    request();
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    expQ.push_back(8'h33);
    sendByte(8'h01, 8'h4B);
    sendByte(8'h02, 8'h11);
    sendByte(8'h02, 8'h22);
    sendByte(8'h02, 8'h33);
    sendByte(8'h02, 8'hAA);
    sendByte(8'h02, 8'hBB);
    stopPacket(8'h00);
    chk("d1_count", {22'h0, RxByteCount}, 32'h3);
    chk("d1_status", {24'h0, RxStatus}, 32'h40);
    chk("d1_drain", expQ.size(), 32'h0);

    // DATA0 with CRC error
    request();
    expQ.push_back(8'h55);
    sendByte(8'h01, 8'hC3);
    sendByte(8'h02, 8'h55);
    sendByte(8'h02, 8'h01);
    sendByte(8'h02, 8'h02);
    stopPacket(8'h01);
    chk("crc_status", {24'h0, RxStatus}, 32'h01);
    chk("crc_count", {22'h0, RxByteCount}, 32'h1);
    chk("crc_pid", {28'h0, RxPID}, 32'h3);

    // Timeout with no START
    request();
    RxTimeOut = 1'b1;
    tick();
    RxTimeOut = 1'b0;
    chk("to_rdy_done", {31'h0, getPacketRdy}, 32'h0);
    tick();
    chk("to_rdy", {31'h0, getPacketRdy}, 32'h1);
    chk("to_status", {24'h0, RxStatus}, 32'h80);
    chk("to_pid", {28'h0, RxPID}, 32'h0);

    // FIFO full on the second write; stray request is ignored
    request();
    expQ.push_back(8'hA0);
    expQ.push_back(8'hA2);
    expQ.push_back(8'hA3);
    sendByte(8'h01, 8'hC3);
    getPacketEn = 1'b1;
    sendByte(8'h02, 8'hA0);
    getPacketEn = 1'b0;
    sendByte(8'h02, 8'hA1);
    sendByte(8'h02, 8'hA2);
    sendByte(8'h02, 8'hA3);
    RxFifoFull = 1'b1;
    sendByte(8'h02, 8'hA4);
    RxFifoFull = 1'b0;
    sendByte(8'h02, 8'hA5);
    stopPacket(8'h00);
    chk("ovf_count", {22'h0, RxByteCount}, 32'h3);
    chk("ovf_status", {24'h0, RxStatus}, 32'h04);
    chk("ovf_drain", expQ.size(), 32'h0);

    // PID check failure
    request();
    sendByte(8'h01, 8'h12);
    sendByte(8'h02, 8'h99);
    stopPacket(8'h00);
    chk("pe_flag", {31'h0, pidError}, 32'h1);
    chk("pe_status", {24'h0, RxStatus}, 32'h0);
    chk("pe_count", {22'h0, RxByteCount}, 32'h0);

    // Abort by a new START in DATA
    request();
    sendByte(8'h01, 8'h4B);
    sendByte(8'h02, 8'h61);
    sendByte(8'h02, 8'h62);
    sendByte(8'h01, 8'hD2);
    stopPacket(8'h00);
    chk("abort_status", {24'h0, RxStatus}, 32'h20);
    chk("abort_pid", {28'h0, RxPID}, 32'h2);

    // Reset mid-DATA
    request();
    expQ.push_back(8'h71);
    sendByte(8'h01, 8'h4B);
    sendByte(8'h02, 8'h71);
    sendByte(8'h02, 8'h72);
    sendByte(8'h02, 8'h73);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_rdy", {31'h0, getPacketRdy}, 32'h1);
    chk("mr_status", {24'h0, RxStatus}, 32'h0);
    chk("mr_pid", {28'h0, RxPID}, 32'h0);
    chk("mr_count", {22'h0, RxByteCount}, 32'h0);
    chk("mr_wen", {31'h0, RxFifoWEn}, 32'h0);
    chk("mr_data", {24'h0, RxFifoData}, 32'h0);
    tick();
    rst = 1'b0;
    sendByte(8'h02, 8'h74);
    sendByte(8'h02, 8'h75);
    tick();
    request();
    sendByte(8'h01, 8'hC3);
    sendByte(8'h02, 8'h81);
    sendByte(8'h02, 8'h82);
    stopPacket(8'h00);
    chk("mr_after_count", {22'h0, RxByteCount}, 32'h0);
    chk("mr_drain", expQ.size(), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatch);
    $finish;
  end

endmodule
